irq_controller_4: RTL and testbench

IRQ_CONTROLLER_4 -- requirements
Module: irq_controller_4

---
 rtl/irq_controller_4.sv | 102 ++++++++++
 tb/tb_irq_controller_4.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller_4.sv
// Four-channel interrupt controller: rising-edge capture into a sticky pending
// register, masking, fixed priority (bit 3 highest) and a present/ack/gap handshake.
module irq_controller_4 #(
    parameter logic [3:0] MASK_RST = 4'b1111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mask_wr,
    input  logic [3:0] mask_in,
    input  logic       ack,
    output logic       irq_valid,
    output logic [1:0] irq_code,
    output logic [3:0] pending,
    output logic [3:0] mask
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_GAP     = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_req_q;
    logic [3:0] r_pending;
    logic [3:0] r_mask;
    logic [1:0] r_code;

    logic [3:0] w_rise;
    logic [3:0] w_active;
    logic [1:0] w_sel;
    logic       w_load_code;
    logic [3:0] w_clr;
    logic [3:0] w_pending_nxt;

    always_comb begin
        w_rise   = req & ~r_req_q;
        w_active = r_pending & r_mask;
        if (w_active[3])      w_sel = 2'd3;
        else if (w_active[2]) w_sel = 2'd2;
        else if (w_active[1]) w_sel = 2'd1;
        else                  w_sel = 2'd0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_code = 1'b0;
        w_clr       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_active != 4'b0000) begin
                    w_state_nxt = S_PRESENT;
                    w_load_code = 1'b1;
                end
            end
            S_PRESENT: begin
                if (ack) begin
                    w_state_nxt = S_GAP;
                    w_clr       = 4'b0001 << r_code;
                end
            end
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // A rise on the channel being cleared wins, so it stays pending.
        w_pending_nxt = (r_pending & ~w_clr) | w_rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_mask    <= MASK_RST;
            r_code    <= '0;
        end else begin
            r_req_q   <= req;
            r_pending <= w_pending_nxt;
            if (mask_wr) begin
                r_mask <= mask_in;
            end
            if (w_load_code) begin
                r_code <= w_sel;
            end
        end
    end

    assign irq_valid = (r_state == S_PRESENT);
    assign irq_code  = r_code;
    assign pending   = r_pending;
    assign mask      = r_mask;

endmodule

// File: tb/tb_irq_controller_4.sv
// Bench for irq_controller_4: directed scenarios plus random traffic, each
// cycle compared against a cycle-level behavioural model of the controller.
module tb_irq_controller_4;

    localparam logic [3:0] MASK_RST = 4'b1111;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       mask_wr;
    logic [3:0] mask_in;
    logic       ack;
    logic       irq_valid;
    logic [1:0] irq_code;
    logic [3:0] pending;
    logic [3:0] mask;

    int tests_run;
    int tests_failed;

    // Behavioural model: a channel is "being served" or not; after service
    // there is a one-cycle hold-off before a new selection may happen.
    logic [3:0] m_pending;
    logic [3:0] m_mask;
    logic [3:0] m_req_prev;
    logic       m_busy;
    int         m_chan;
    int         m_hold;

    irq_controller_4 #(.MASK_RST(MASK_RST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .ack       (ack),
        .irq_valid (irq_valid),
        .irq_code  (irq_code),
        .pending   (pending),
        .mask      (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pending  = '0;
        m_mask     = MASK_RST;
        m_req_prev = '0;
        m_busy     = 1'b0;
        m_chan     = 0;
        m_hold     = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic mw, input logic [3:0] mi, input logic a);
        logic [3:0] rise;
        logic       found;
        rise  = r & ~m_req_prev;
        found = 1'b0;
        if (m_busy) begin
            if (a) begin
                m_pending[m_chan] = 1'b0;
                m_busy = 1'b0;
                m_hold = 1;
            end
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (!found && m_pending[i] && m_mask[i]) begin
                    found  = 1'b1;
                    m_chan = i;
                    m_busy = 1'b1;
                end
            end
        end
        m_pending  = m_pending | rise;
        if (mw) m_mask = mi;
        m_req_prev = r;
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input logic [3:0] r, input logic mw, input logic [3:0] mi, input logic a);
        req     = r;
        mask_wr = mw;
        mask_in = mi;
        ack     = a;
        @(posedge clk);
        model_edge(r, mw, mi, a);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0; mask_wr = 1'b0; mask_in = '0; ack = 1'b0;
        model_reset();
        #12;
        tests_run++;
        if ({irq_valid, irq_code, pending, mask} !== {1'b0, 2'b00, 4'b0000, MASK_RST}) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b c=%0d p=%b m=%b, expected v=0 c=0 p=0000 m=%b",
                     irq_valid, irq_code, pending, mask, MASK_RST);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Vector encoding: {req[3:0], mask_wr, mask_in[3:0], ack}
    task automatic test_single();
        logic [9:0] t [5] = '{{4'b0001,1'b0,4'b0000,1'b0}, {4'b0001,1'b0,4'b0000,1'b0},
                              {4'b0001,1'b0,4'b0000,1'b0}, {4'b0001,1'b0,4'b0000,1'b1},
                              {4'b0000,1'b0,4'b0000,1'b0}};
        for (int k = 0; k < 5; k++) begin
            step(t[k][9:6], t[k][5], t[k][4:1], t[k][0]);
            tests_run++;
            if ({irq_valid, pending, mask} !== {m_busy, m_pending, m_mask}) begin
                tests_failed++;
                $display("FAIL single_model[%0d]: got v=%b p=%b m=%b, expected v=%b p=%b m=%b",
                         k, irq_valid, pending, mask, m_busy, m_pending, m_mask);
            end
            if (m_busy) begin
                tests_run++;
                if (irq_code !== m_chan[1:0]) begin
                    tests_failed++;
                    $display("FAIL single_code[%0d]: got %0d expected %0d", k, irq_code, m_chan);
                end
            end
            if (k == 0) begin
                tests_run++;
                if ({irq_valid, pending} !== {1'b0, 4'b0001}) begin
                    tests_failed++;
                    $display("FAIL single_pend: got v=%b p=%b expected v=0 p=0001", irq_valid, pending);
                end
            end
            if (k == 1) begin
                tests_run++;
                if ({irq_valid, irq_code} !== {1'b1, 2'd0}) begin
                    tests_failed++;
                    $display("FAIL single_present: got v=%b c=%0d expected v=1 c=0", irq_valid, irq_code);
                end
            end
            if (k == 3) begin
                tests_run++;
                if ({irq_valid, pending} !== {1'b0, 4'b0000}) begin
                    tests_failed++;
                    $display("FAIL single_ack: got v=%b p=%b expected v=0 p=0000", irq_valid, pending);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [9:0] t [7] = '{{4'b0101,1'b0,4'b0000,1'b0}, {4'b0101,1'b0,4'b0000,1'b0},
                              {4'b0101,1'b0,4'b0000,1'b1}, {4'b0101,1'b0,4'b0000,1'b0},
                              {4'b0101,1'b0,4'b0000,1'b0}, {4'b0101,1'b0,4'b0000,1'b1},
                              {4'b0000,1'b0,4'b0000,1'b0}};
        for (int k = 0; k < 7; k++) begin
            step(t[k][9:6], t[k][5], t[k][4:1], t[k][0]);
            tests_run++;
            if ({irq_valid, pending, mask} !== {m_busy, m_pending, m_mask}) begin
                tests_failed++;
                $display("FAIL prio_model[%0d]: got v=%b p=%b m=%b, expected v=%b p=%b m=%b",
                         k, irq_valid, pending, mask, m_busy, m_pending, m_mask);
            end
            if (m_busy) begin
                tests_run++;
                if (irq_code !== m_chan[1:0]) begin
                    tests_failed++;
                    $display("FAIL prio_code[%0d]: got %0d expected %0d", k, irq_code, m_chan);
                end
            end
            if (k == 1 || k == 4) begin
                tests_run++;
                if ({irq_valid, irq_code} !== {1'b1, (k == 1) ? 2'd2 : 2'd0}) begin
                    tests_failed++;
                    $display("FAIL prio_order[%0d]: got v=%b c=%0d expected v=1 c=%0d",
                             k, irq_valid, irq_code, (k == 1) ? 2 : 0);
                end
            end
            if (k == 3) begin
                tests_run++;
                if (irq_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL prio_gap: got v=%b expected v=0", irq_valid);
                end
            end
            if (k == 5) begin
                tests_run++;
                if (pending !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL prio_clear: got p=%b expected 0000", pending);
                end
            end
        end
    endtask

    task automatic test_mask();
        logic [9:0] t [8] = '{{4'b0000,1'b1,4'b1011,1'b0}, {4'b0100,1'b0,4'b0000,1'b0},
                              {4'b0100,1'b0,4'b0000,1'b1}, {4'b0100,1'b0,4'b0000,1'b0},
                              {4'b0100,1'b1,4'b1111,1'b0}, {4'b0100,1'b0,4'b0000,1'b0},
                              {4'b0100,1'b0,4'b0000,1'b1}, {4'b0000,1'b0,4'b0000,1'b0}};
        for (int k = 0; k < 8; k++) begin
            step(t[k][9:6], t[k][5], t[k][4:1], t[k][0]);
            tests_run++;
            if ({irq_valid, pending, mask} !== {m_busy, m_pending, m_mask}) begin
                tests_failed++;
                $display("FAIL mask_model[%0d]: got v=%b p=%b m=%b, expected v=%b p=%b m=%b",
                         k, irq_valid, pending, mask, m_busy, m_pending, m_mask);
            end
            if (m_busy) begin
                tests_run++;
                if (irq_code !== m_chan[1:0]) begin
                    tests_failed++;
                    $display("FAIL mask_code[%0d]: got %0d expected %0d", k, irq_code, m_chan);
                end
            end
            if (k == 3) begin
                tests_run++;
                if ({irq_valid, pending, mask} !== {1'b0, 4'b0100, 4'b1011}) begin
                    tests_failed++;
                    $display("FAIL mask_blocked: got v=%b p=%b m=%b expected v=0 p=0100 m=1011",
                             irq_valid, pending, mask);
                end
            end
            if (k == 5) begin
                tests_run++;
                if ({irq_valid, irq_code} !== {1'b1, 2'd2}) begin
                    tests_failed++;
                    $display("FAIL mask_unblock: got v=%b c=%0d expected v=1 c=2", irq_valid, irq_code);
                end
            end
        end
    endtask

    task automatic test_stability();
        logic [9:0] t [9] = '{{4'b0010,1'b0,4'b0000,1'b0}, {4'b0010,1'b0,4'b0000,1'b0},
                              {4'b1010,1'b0,4'b0000,1'b0}, {4'b1010,1'b1,4'b0000,1'b0},
                              {4'b1010,1'b1,4'b1111,1'b1}, {4'b1010,1'b0,4'b0000,1'b0},
                              {4'b1010,1'b0,4'b0000,1'b0}, {4'b1010,1'b0,4'b0000,1'b1},
                              {4'b0000,1'b0,4'b0000,1'b0}};
        for (int k = 0; k < 9; k++) begin
            step(t[k][9:6], t[k][5], t[k][4:1], t[k][0]);
            tests_run++;
            if ({irq_valid, pending, mask} !== {m_busy, m_pending, m_mask}) begin
                tests_failed++;
                $display("FAIL stab_model[%0d]: got v=%b p=%b m=%b, expected v=%b p=%b m=%b",
                         k, irq_valid, pending, mask, m_busy, m_pending, m_mask);
            end
            if (m_busy) begin
                tests_run++;
                if (irq_code !== m_chan[1:0]) begin
                    tests_failed++;
                    $display("FAIL stab_code[%0d]: got %0d expected %0d", k, irq_code, m_chan);
                end
            end
            if (k == 3) begin
                tests_run++;
                if ({irq_valid, irq_code} !== {1'b1, 2'd1}) begin
                    tests_failed++;
                    $display("FAIL stab_hold: got v=%b c=%0d expected v=1 c=1", irq_valid, irq_code);
                end
            end
            if (k == 6) begin
                tests_run++;
                if ({irq_valid, irq_code} !== {1'b1, 2'd3}) begin
                    tests_failed++;
                    $display("FAIL stab_next: got v=%b c=%0d expected v=1 c=3", irq_valid, irq_code);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [9:0] t [7] = '{{4'b0010,1'b0,4'b0000,1'b0}, {4'b0000,1'b0,4'b0000,1'b0},
                              {4'b0000,1'b0,4'b0000,1'b0}, {4'b0010,1'b0,4'b0000,1'b1},
                              {4'b0010,1'b0,4'b0000,1'b0}, {4'b0010,1'b0,4'b0000,1'b0},
                              {4'b0000,1'b0,4'b0000,1'b1}};
        for (int k = 0; k < 7; k++) begin
            step(t[k][9:6], t[k][5], t[k][4:1], t[k][0]);
            tests_run++;
            if ({irq_valid, pending, mask} !== {m_busy, m_pending, m_mask}) begin
                tests_failed++;
                $display("FAIL coll_model[%0d]: got v=%b p=%b m=%b, expected v=%b p=%b m=%b",
                         k, irq_valid, pending, mask, m_busy, m_pending, m_mask);
            end
            if (m_busy) begin
                tests_run++;
                if (irq_code !== m_chan[1:0]) begin
                    tests_failed++;
                    $display("FAIL coll_code[%0d]: got %0d expected %0d", k, irq_code, m_chan);
                end
            end
            if (k == 3) begin
                tests_run++;
                if ({irq_valid, pending} !== {1'b0, 4'b0010}) begin
                    tests_failed++;
                    $display("FAIL coll_setwins: got v=%b p=%b expected v=0 p=0010", irq_valid, pending);
                end
            end
            if (k == 5) begin
                tests_run++;
                if ({irq_valid, irq_code} !== {1'b1, 2'd1}) begin
                    tests_failed++;
                    $display("FAIL coll_repres: got v=%b c=%0d expected v=1 c=1", irq_valid, irq_code);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step(4'b0000, 1'b1, 4'b0110, 1'b0);
        step(4'b0100, 1'b0, 4'b0000, 1'b0);
        step(4'b0100, 1'b0, 4'b0000, 1'b0);
        tests_run++;
        if ({irq_valid, irq_code, mask} !== {1'b1, 2'd2, 4'b0110}) begin
            tests_failed++;
            $display("FAIL rmid_pre: got v=%b c=%0d m=%b expected v=1 c=2 m=0110", irq_valid, irq_code, mask);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({irq_valid, irq_code, pending, mask} !== {1'b0, 2'b00, 4'b0000, MASK_RST}) begin
            tests_failed++;
            $display("FAIL rmid_async: got v=%b c=%0d p=%b m=%b expected v=0 c=0 p=0000 m=%b",
                     irq_valid, irq_code, pending, mask, MASK_RST);
        end
        #2 rst_n = 1'b1;
        step(4'b0100, 1'b0, 4'b0000, 1'b0);
        tests_run++;
        if ({irq_valid, pending} !== {1'b0, 4'b0100}) begin
            tests_failed++;
            $display("FAIL rmid_rise: got v=%b p=%b expected v=0 p=0100", irq_valid, pending);
        end
        step(4'b0100, 1'b0, 4'b0000, 1'b0);
        tests_run++;
        if ({irq_valid, irq_code} !== {1'b1, 2'd2}) begin
            tests_failed++;
            $display("FAIL rmid_fresh: got v=%b c=%0d expected v=1 c=2", irq_valid, irq_code);
        end
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       mw;
        logic [3:0] mi;
        logic       a;
        for (int k = 0; k < 400; k++) begin
            r  = 4'($urandom_range(0, 15));
            mw = ($urandom_range(0, 7) == 0);
            mi = 4'($urandom_range(0, 15));
            a  = 1'($urandom_range(0, 1));
            step(r, mw, mi, a);
            tests_run++;
            if ({irq_valid, pending, mask} !== {m_busy, m_pending, m_mask}) begin
                tests_failed++;
                $display("FAIL rand_model[%0d]: got v=%b p=%b m=%b, expected v=%b p=%b m=%b",
                         k, irq_valid, pending, mask, m_busy, m_pending, m_mask);
            end
            if (m_busy) begin
                tests_run++;
                if (irq_code !== m_chan[1:0]) begin
                    tests_failed++;
                    $display("FAIL rand_code[%0d]: got %0d expected %0d", k, irq_code, m_chan);
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        step(4'b0000, 1'b1, 4'b1111, 1'b0);
        test_stability();
        test_collision();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
